serial_subtractor: RTL and testbench

- Bit-serial N-bit unsigned subtractor that computes A − B one bit per clock, LSB first.
- Built around a single full-subtractor cell: a half-subtractor pair plus a registered borrow.
- Sits downstream of operand sources and upstream of any result consumer, with valid/ready handshakes on both sides.
- Trades latency (WIDTH cycles) for a single-bit datapath.

---
 rtl/serial_arith_pkg.sv | 15 +
 rtl/full_subtractor_bit.sv | 34 +++
 rtl/serial_subtractor.sv | 97 +++++++++
 tb/tb_serial_subtractor.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared types and defaults for the bit-serial arithmetic blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_arith_pkg;

    // Operation sequencing: wait for operands, shift WIDTH bits, hold the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ser_state_e;

    parameter int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: diff = a - b - bin, with borrow out.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   a_i    minuend bit
//   b_i    subtrahend bit
//   bin_i  incoming borrow
//   diff_o difference bit
//   bout_o outgoing borrow
module full_subtractor_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic diff_o,
    output logic bout_o
);

    logic hs1_diff;
    logic hs1_borrow;
    logic hs2_borrow;

    // First half subtractor: a - b.
    assign hs1_diff   = a_i ^ b_i;
    assign hs1_borrow = ~a_i & b_i;

    // Second half subtractor: (a - b) - bin.
    assign diff_o     = hs1_diff ^ bin_i;
    assign hs2_borrow = ~hs1_diff & bin_i;

    // The two stages can never both borrow, so OR merges them.
    assign bout_o     = hs1_borrow | hs2_borrow;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned A - B, LSB first, one full-subtractor cell plus a borrow flop.
// Latency: out_valid_o rises WIDTH edges after the accepting edge; one op in flight.
// Backpressure: result held in DONE until out_ready_i; in_ready_o only high in IDLE.
//
// Ports:
//   clk, reset               clock, async active-high reset
//   in_valid_i / in_ready_o  operand handshake (a_i minuend, b_i subtrahend)
//   out_valid_o / out_ready_i result handshake (diff_o, borrow_o)
//   busy_o                   high while bits are being shifted
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
    output logic             busy_o
);

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    ser_state_e       state;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_sr;
    logic             borrow_q;

    logic             d_bit;
    logic             bout_bit;

    full_subtractor_bit u_fs (
        .a_i    (a_sr[0]),
        .b_i    (b_sr[0]),
        .bin_i  (borrow_q),
        .diff_o (d_bit),
        .bout_o (bout_bit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            a_sr     <= '0;
            b_sr     <= '0;
            diff_sr  <= '0;
            borrow_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        a_sr     <= a_i;
                        b_sr     <= b_i;
                        borrow_q <= 1'b0;
                        bit_cnt  <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sr     <= a_sr >> 1;
                    b_sr     <= b_sr >> 1;
                    // Difference bits enter at the MSB so that after WIDTH
                    // shifts the first (LSB) bit has reached position 0.
                    diff_sr  <= {d_bit, diff_sr[WIDTH-1:1]};
                    borrow_q <= bout_bit;
                    bit_cnt  <= bit_cnt + 1'b1;
                    // Counter still holds WIDTH-1 on the last of WIDTH RUN edges.
                    if (bit_cnt == CNT_LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = (state == IDLE);
    assign out_valid_o = (state == DONE);
    assign busy_o      = (state == RUN);
    assign diff_o      = diff_sr;
    assign borrow_o    = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk         = 1'b0;
    logic         reset       = 1'b1;
    logic         in_valid_i  = 1'b0;
    logic         out_ready_i = 1'b0;
    logic [W-1:0] a_i         = '0;
    logic [W-1:0] b_i         = '0;
    logic         in_ready_o;
    logic         out_valid_o;
    logic [W-1:0] diff_o;
    logic         borrow_o;
    logic         busy_o;

    int checks   = 0;
    int failures = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .diff_o      (diff_o),
        .borrow_o    (borrow_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain modular arithmetic on integers.
    function automatic logic [W-1:0] ref_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned ai = a;
        int unsigned bi = b;
        return W'((ai + (1 << W) - bi) % (1 << W));
    endfunction

    function automatic logic ref_borrow(input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned ai = a;
        int unsigned bi = b;
        return (ai < bi);
    endfunction

    // noise: 0 = quiet during RUN, 1 = in_valid with a/b = FF, 2 = in_valid with random a/b
    // next_valid: present in_valid with new operands in the handshake cycle of DONE
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int stall,
                         input int noise, input bit next_valid,
                         input logic [W-1:0] na, input logic [W-1:0] nb);
        int           edges;
        int           busy_cnt;
        bit           bad_rdy;
        logic [W-1:0] held_d;
        logic         held_b;
        edges = 0;
        while (!in_ready_o && edges < 100) begin
            @(posedge clk); #1; edges++;
        end
        a_i = a; b_i = b; in_valid_i = 1'b1; out_ready_i = 1'b0;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        edges = 0; busy_cnt = 0; bad_rdy = 0;
        while (!out_valid_o && edges < 100) begin
            if (noise == 1) begin
                in_valid_i = 1'b1; a_i = 8'hFF; b_i = 8'hFF;
            end else if (noise == 2) begin
                in_valid_i = 1'b1; a_i = W'($urandom); b_i = W'($urandom);
            end
            if (busy_o) busy_cnt++;
            if (in_ready_o) bad_rdy = 1;
            @(posedge clk); #1; edges++;
        end
        chk("latency", edges, W);
        chk("busy_cycles", busy_cnt, W);
        chk("no_ready_in_run", bad_rdy, 0);
        chk("diff", diff_o, ref_diff(a, b));
        chk("borrow", borrow_o, ref_borrow(a, b));
        held_d = diff_o;
        held_b = borrow_o;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk("stall_valid", out_valid_o, 1'b1);
            chk("stall_diff", diff_o, held_d);
            chk("stall_borrow", borrow_o, held_b);
            chk("stall_no_ready", in_ready_o, 1'b0);
        end
        out_ready_i = 1'b1;
        if (next_valid) begin
            in_valid_i = 1'b1; a_i = na; b_i = nb;
        end else begin
            in_valid_i = 1'b0;
        end
        @(posedge clk); #1;
        out_ready_i = 1'b0;
        chk("after_hs_valid", out_valid_o, 1'b0);
        chk("after_hs_ready", in_ready_o, 1'b1);
        chk("after_hs_not_busy", busy_o, 1'b0);
    endtask

    initial begin
        #12;
        chk("rst_in_ready", in_ready_o, 1'b1);
        chk("rst_out_valid", out_valid_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_diff", diff_o, 0);
        chk("rst_borrow", borrow_o, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;

        do_op(8'h05, 8'h03, 0, 0, 0, 8'h00, 8'h00);
        do_op(8'h03, 8'h05, 0, 0, 0, 8'h00, 8'h00);
        do_op(8'h00, 8'hFF, 0, 0, 0, 8'h00, 8'h00);
        do_op(8'hA5, 8'hA5, 0, 0, 0, 8'h00, 8'h00);
        // Backpressure: five stalled DONE cycles.
        do_op(8'h3C, 8'h71, 5, 0, 0, 8'h00, 8'h00);
        // Operands wiggled with in_valid high throughout RUN; the result
        // handshake also carries new operands, which must wait for IDLE.
        do_op(8'h10, 8'h01, 2, 1, 1, 8'h20, 8'h10);
        // Still IDLE here (checked in do_op); the held operands go in now.
        do_op(8'h20, 8'h10, 0, 0, 0, 8'h00, 8'h00);

        // Reset asynchronously in the 4th RUN cycle.
        a_i = 8'h55; b_i = 8'h11; in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready_o, 1'b1);
        chk("midrst_out_valid", out_valid_o, 1'b0);
        chk("midrst_busy", busy_o, 1'b0);
        chk("midrst_diff", diff_o, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        do_op(8'h80, 8'h01, 0, 0, 0, 8'h00, 8'h00);

        for (int i = 0; i < 1000; i++) begin
            do_op(W'($urandom), W'($urandom), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 2)), 1'b0, 8'h00, 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
